rsi_price_feeder: RTL
=====================

Name: rsi_price_feeder

Overview:
Front-end price source for the RSI datapath. It accepts a serial stream of uq8_8_t prices over a valid/ready handshake and builds the N-sample window. It drives the seed interface (o_prices, o_en) once the window is first full, then the incremental interface (o_curr_price, o_valid_price) for every later sample. It throttles the source so the sequential RS/RSI pipeline is never overrun.

Parameters:
N, 14, window length in samples; must match the downstream RS block.
G_SEED_GAP, 8, cycles after the o_en pulse during which input is stalled so the downstream seed computation can complete.
G_GAP, 4, cycles after each o_valid_price pulse during which input is stalled; 0 allows back-to-back samples.

Ports:
i_clk  in  1  clock; all logic on the rising edge.
i_rst  in  1  reset, synchronous, active-high.
i_flush  in  1  synchronous window clear; returns the block to FILL.
i_price  in  16 (uq8_8_t)  incoming price.
i_price_valid  in  1  i_price is valid.
o_price_ready  out  1  block accepts i_price this cycle.
o_prices  out  N x 16 (uq8_8_t)  window; [0] is the oldest sample, [N-1] the newest.
o_en  out  1  one-cycle seed strobe; o_prices holds a complete first window.
o_curr_price  out  16 (uq8_8_t)  newest sample in RUN.
o_valid_price  out  1  one-cycle strobe qualifying o_curr_price.
o_fill_count  out  clog2(N+1)  number of samples in the window, saturating at N.

Behaviour:
- Accept condition: i_price_valid && o_price_ready. o_price_ready is combinational: (state==FILL || state==RUN) && !i_flush && !i_rst.
- Reset (i_rst=1 at a clock edge):
  - state=FILL; all o_prices=0; o_curr_price=0; o_en=0; o_valid_price=0; o_fill_count=0; gap counter=0.
  - i_rst overrides every other input, in any state.
- FILL:
  - On accept: shift the window left (o_prices[k] <= o_prices[k+1]); o_prices[N-1] <= i_price; o_fill_count++.
  - The accept that makes the count reach N moves the state to SEED. o_en=1 in the next cycle, with the full window visible in that same cycle.
- SEED:
  - Exactly one cycle; o_en=1; ready=0.
  - Load gap counter with G_SEED_GAP, then go to SEED_WAIT (straight to RUN if G_SEED_GAP=0).
- SEED_WAIT:
  - ready=0; decrement the counter each cycle; go to RUN when it reaches 0.
  - Stall length is exactly G_SEED_GAP cycles after the SEED cycle.
- RUN:
  - ready=1. On accept: shift the window as in FILL, o_curr_price <= i_price, o_valid_price=1 in the next cycle.
  - o_prices[N-1]==o_curr_price while o_valid_price=1.
  - If G_GAP>0: go to GAP and load the counter with G_GAP. If G_GAP=0: stay in RUN, so one sample per cycle is allowed.
- GAP:
  - ready=0 for exactly G_GAP cycles, then RUN.
  - A held i_price_valid is not consumed; the source holds i_price stable.
- Latency: an accepted sample is visible on o_prices, o_curr_price and the strobes one cycle after acceptance.
- Strobes: o_en and o_valid_price are single-cycle and never asserted together. o_en fires once per fill, i.e. after reset and after each flush.
- o_fill_count: saturates at N in SEED, SEED_WAIT, RUN and GAP.
- i_flush (any state, i_rst=0):
  - Next state FILL; o_prices cleared to 0; o_fill_count=0; pending strobes cleared next cycle.
  - A sample presented in the flush cycle is not accepted, because ready=0.
- No arithmetic: prices pass through unmodified, 16-bit uq8_8_t, no saturation.

Test Plan:
- Fill, N=14, G_SEED_GAP=8: push 0x0100..0x0E00 with valid held high.
  -> o_en high for one cycle, exactly 1 cycle after the 14th accept.
  -> o_prices[0]=0x0100, o_prices[13]=0x0E00, o_fill_count=14.
  -> ready low for 9 cycles (the SEED cycle plus 8 wait cycles).
- RUN step: after the seed, push 0x0F00.
  -> Next cycle: o_valid_price=1, o_curr_price=0x0F00, o_prices[0]=0x0200, o_prices[13]=0x0F00, o_en=0.
- Throttle, G_GAP=4: hold valid high with 0x1000 then 0x1100.
  -> Exactly 4 ready-low cycles between the two accepts.
  -> 0x1000 is not duplicated; exactly two o_valid_price pulses.
- G_GAP=0: stream 0x2000, 0x2100, 0x2200 on consecutive cycles.
  -> Three consecutive o_valid_price pulses carrying those values in order.
- Flush mid-FILL: assert i_flush with valid high after 5 samples.
  -> o_fill_count=0, o_prices all 0, the flush-cycle sample is dropped.
  -> The next 14 samples produce exactly one o_en.
- Reset in GAP: assert i_rst for 1 cycle.
  -> All outputs are at their reset values next cycle and ready=1 the cycle after.
  -> No o_valid_price pulse until a fresh fill and seed complete.

Source files
------------

// File: rtl/rsi_price_feeder.sv
// rsi_price_feeder
// Front-end price source for the RSI datapath. Collects a serial stream of
// uq8_8 prices into an N-sample sliding window. It issues a one-shot seed
// strobe when the window first fills. After that it issues one incremental
// strobe per new sample. Intake is throttled so the sequential RS/RSI stages
// downstream always have time to finish before the next sample arrives.

module rsi_price_feeder #(
  parameter int N          = 14,
  parameter int G_SEED_GAP = 8,
  parameter int G_GAP      = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic [15:0]                i_price,
  input  logic                       i_price_valid,
  output logic                       o_price_ready,
  output logic [N-1:0][15:0]         o_prices,
  output logic                       o_en,
  output logic [15:0]                o_curr_price,
  output logic                       o_valid_price,
  output logic [$clog2(N+1)-1:0]     o_fill_count
);

  localparam int FW   = $clog2(N + 1);
  localparam int GMAX = (G_SEED_GAP > G_GAP) ? G_SEED_GAP : G_GAP;
  localparam int CW   = (GMAX > 0) ? $clog2(GMAX + 1) : 1;

  typedef enum logic [2:0] {
    FILL,
    SEED,
    SEED_WAIT,
    RUN,
    GAP
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   gap_cnt;
  logic            accept;

  // State register; reset and flush both return to FILL.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (i_rst) state <= FILL;
    else       state <= state_n;
  end

  // Next-state, handshake and seed strobe decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_n       = state;
    o_price_ready = ((state == FILL) || (state == RUN)) && !i_flush && !i_rst;
    accept        = i_price_valid && o_price_ready;
    o_en          = (state == SEED);

    unique case (state)
      FILL: begin
        if (accept && (o_fill_count == FW'(N - 1))) state_n = SEED;
      end
      SEED: begin
        state_n = (G_SEED_GAP == 0) ? RUN : SEED_WAIT;
      end
      SEED_WAIT: begin
        if (gap_cnt == CW'(1)) state_n = RUN;
      end
      RUN: begin
        if (accept && (G_GAP != 0)) state_n = GAP;
      end
      GAP: begin
        if (gap_cnt == CW'(1)) state_n = RUN;
      end
      default: state_n = FILL;
    endcase

    if (i_flush) state_n = FILL;
  end

  // Window shift register, incremental outputs, fill count and stall counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the window is an externally visible output with defined reset
      // contents, so it is reset like any control register rather than
      // being left as uninitialised storage.
      o_prices      <= '0;
      o_curr_price  <= '0;
      o_valid_price <= 1'b0;
      o_fill_count  <= '0;
      gap_cnt       <= '0;
    end else if (i_flush) begin
      o_prices      <= '0;
      o_valid_price <= 1'b0;
      o_fill_count  <= '0;
      gap_cnt       <= '0;
    end else begin
      o_valid_price <= 1'b0;

      if (accept) begin
        // Index 0 is the oldest sample; new samples enter at N-1.
        o_prices <= {i_price, o_prices[N-1:1]};
        if (state == FILL) o_fill_count <= o_fill_count + FW'(1);
        if (state == RUN) begin
          o_curr_price  <= i_price;
          o_valid_price <= 1'b1;
        end
      end

      unique case (state)
        SEED:           gap_cnt <= CW'(G_SEED_GAP);
        SEED_WAIT, GAP: gap_cnt <= gap_cnt - CW'(1);
        RUN:            if (accept) gap_cnt <= CW'(G_GAP);
        default:        gap_cnt <= gap_cnt;
      endcase
    end
  end

endmodule
